// File: rtl/div_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : div_unit_if
// Purpose  : Request/result bundle between the execute stage and div_unit.
// Revision : 1.0 - initial release
// ============================================================================
interface div_unit_if;
  logic        div_en;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        exc_flush;
  logic        div_block;
  logic        div_done;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  modport master (
    output div_en, div_signed, div_src1, div_src2, exc_flush,
    input  div_block, div_done, div_lo, div_hi
  );

  modport slave (
    input  div_en, div_signed, div_src1, div_src2, exc_flush,
    output div_block, div_done, div_lo, div_hi
  );
endinterface
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : 32-bit signed/unsigned restoring divider, one quotient bit per
//            cycle. Optional macro DIV_ZERO_FAST_EN short-cuts divide-by-zero.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit (
  input  wire logic  clk,
  input  wire logic  reset,
  div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_rem;
  logic [31:0] r_dvsr;
  logic        r_q_neg;
  logic        r_r_neg;
  logic [31:0] r_lo;
  logic [31:0] r_hi;

  logic        w_start;
  logic        w_step;
  logic        w_load;
  logic        w_zero;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [64:0] w_shift;
  logic [32:0] w_trial;
  logic [63:0] w_rem_nxt;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_hi_nxt;

  assign w_abs1 = (div_if.div_signed && div_if.div_src1[31]) ?
                  (~div_if.div_src1 + 32'd1) : div_if.div_src1;
  assign w_abs2 = (div_if.div_signed && div_if.div_src2[31]) ?
                  (~div_if.div_src2 + 32'd1) : div_if.div_src2;
  assign w_zero = (div_if.div_src2 == 32'd0);

  // Upper half is the partial remainder, lower half shifts dividend out and
  // quotient bits in. Bit 64 of the shift keeps the trial compare exact.
  assign w_shift   = {r_rem, 1'b0};
  assign w_trial   = w_shift[64:32] - {1'b0, r_dvsr};
  assign w_rem_nxt = w_trial[32] ? w_shift[63:0]
                                 : {w_trial[31:0], w_shift[31:1], 1'b1};

  assign w_q_fin = r_q_neg ? (~w_rem_nxt[31:0]  + 32'd1) : w_rem_nxt[31:0];
  assign w_r_fin = r_r_neg ? (~w_rem_nxt[63:32] + 32'd1) : w_rem_nxt[63:32];

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_load   = 1'b0;
    w_lo_nxt = w_q_fin;
    w_hi_nxt = w_r_fin;
    case (r_state)
      S_IDLE: begin
        if (div_if.div_en && !div_if.exc_flush) begin
          w_start = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          if (w_zero) begin
            w_next   = S_DONE;
            w_load   = 1'b1;
            w_lo_nxt = 32'hFFFF_FFFF;
            w_hi_nxt = div_if.div_src1;
          end else begin
            w_next = S_CALC;
          end
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        // Dropping div_en mid-operation is an abort, same as a flush.
        if (div_if.exc_flush || !div_if.div_en) begin
          w_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == 5'd31) begin
            w_next = S_DONE;
            w_load = 1'b1;
          end
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_rem   <= 64'd0;
      r_dvsr  <= 32'd0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_rem   <= {32'd0, w_abs1};
        r_dvsr  <= w_abs2;
        // Zero divisor keeps the all-ones quotient unnegated.
        r_q_neg <= div_if.div_signed & (div_if.div_src1[31] ^ div_if.div_src2[31]) & ~w_zero;
        r_r_neg <= div_if.div_signed & div_if.div_src1[31];
        r_cnt   <= 5'd0;
      end else if (w_step) begin
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_load) begin
        r_lo <= w_lo_nxt;
        r_hi <= w_hi_nxt;
      end
    end
  end

  assign div_if.div_block = div_if.div_en && (r_state != S_DONE);
  assign div_if.div_done  = (r_state == S_DONE) && !div_if.exc_flush;
  assign div_if.div_lo    = r_lo;
  assign div_if.div_hi    = r_hi;

endmodule
`default_nettype wire
